uart_tx_feeder: RTL



---
 rtl/uart_tx_feeder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus transmit sequencer feeding a UART transmitter one frame at a time.
// Bytes are buffered at full clock rate and released only after the previous frame reports done.
module uart_tx_feeder #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    input  logic          tx_done,
    output logic          sending
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] LVL_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_EMPTY = (AW + 1)'(0);
    localparam logic [AW:0] LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [AW:0]   level_r;
    logic          full_r;
    logic          empty_r;
    logic          ovf_r;
    logic [7:0]    tx_data_r;
    logic          tx_start_r;
    logic          sending_r;
    state_t        state_r;

    logic          push_s;
    logic          drop_s;
    logic          pop_s;
    logic [AW:0]   level_nxt_s;

    // Push/pop qualification; full is the registered flag, so a pop never frees room the same cycle.
    always_comb begin
        push_s = wr_en & ~full_r;
        drop_s = wr_en & full_r;
        pop_s  = (state_r == IDLE) & ~empty_r & ~tx_busy;
    end

    // Next fill level from the push/pop combination.
    always_comb begin
        level_nxt_s = level_r;
        if (push_s && !pop_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Storage array; contents survive reset but become unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wp_r] <= wr_data;
        end
    end

    // Pointers, level, status flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_r    <= '0;
            rp_r    <= '0;
            level_r <= LVL_EMPTY;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wp_r <= wp_r + PTR_ONE;
            end
            if (pop_s) begin
                rp_r <= rp_r + PTR_ONE;
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LVL_FULL);
            empty_r <= (level_nxt_s == LVL_EMPTY);
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Transmit sequencer; tx_start is registered so it is high exactly while in START.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tx_data_r  <= 8'h00;
            tx_start_r <= 1'b0;
            sending_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        tx_data_r  <= mem_r[rp_r];
                        tx_start_r <= 1'b1;
                        sending_r  <= 1'b1;
                        state_r    <= START;
                    end else begin
                        tx_start_r <= 1'b0;
                    end
                end
                START: begin
                    tx_start_r <= 1'b0;
                    state_r    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    tx_start_r <= 1'b0;
                    if (tx_done) begin
                        sending_r <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    sending_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign full     = full_r;
    assign empty    = empty_r;
    assign level    = level_r;
    assign overflow = ovf_r;
    assign tx_data  = tx_data_r;
    assign tx_start = tx_start_r;
    assign sending  = sending_r;

endmodule
